// File: rtl/bcd_to_bin_pkg.sv
// Shared parameters and FSM encodings for the BCD <-> binary converters.
package bcd_to_bin_pkg;

    // Default measurement resolution and number of decimal digits
    localparam int unsigned RES_WIDTH      = 14;
    localparam int unsigned DECIMAL_DIGITS = 4;

    // One-hot state encodings, shared with the forward converter
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_SHIFT = 4'b0010;
    localparam logic [3:0] ST_CHECK = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    // A BCD nibble is invalid when it encodes a value above 9
    function automatic logic bcd_nibble_invalid(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

endpackage : bcd_to_bin_pkg

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one digit adjust per cycle).
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int unsigned WIDTH  = RES_WIDTH,
    parameter int unsigned DIGITS = DECIMAL_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   bcd_i,
    input  logic                  start_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      binary_o,
    output logic                  err_o,
    output logic                  ovf_o
);

    localparam int unsigned BCD_W  = DIGITS * 4;
    localparam int unsigned DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LCNT_W = $clog2(WIDTH + 1);

    logic [3:0]        state_q,     state_d;
    logic [BCD_W-1:0]  bcd_q,       bcd_d;
    logic [WIDTH-1:0]  bin_q,       bin_d;
    logic [DIDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [LCNT_W-1:0] loop_cnt_q,  loop_cnt_d;
    logic              req_err_q,   req_err_d;
    logic              ready_q,     ready_d;
    logic              done_q,      done_d;
    logic [WIDTH-1:0]  binary_q,    binary_d;
    logic              err_q,       err_d;
    logic              ovf_q,       ovf_d;

    logic [DIGITS-1:0] nib_bad;
    logic              any_nib_bad;

    // Per-nibble validity check on the incoming request
    for (genvar g = 0; g < DIGITS; g++) begin : g_nib_chk
        assign nib_bad[g] = bcd_nibble_invalid(bcd_i[g*4 +: 4]);
    end
    assign any_nib_bad = |nib_bad;

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            digit_idx_q <= '0;
            loop_cnt_q  <= '0;
            req_err_q   <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            binary_q    <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            digit_idx_q <= digit_idx_d;
            loop_cnt_q  <= loop_cnt_d;
            req_err_q   <= req_err_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            binary_q    <= binary_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, datapath and result logic
    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        digit_idx_d = digit_idx_q;
        loop_cnt_d  = loop_cnt_q;
        req_err_d   = req_err_q;
        done_d      = 1'b0;
        binary_d    = binary_q;
        err_d       = err_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bcd_d       = bcd_i;
                    bin_d       = '0;
                    digit_idx_d = '0;
                    loop_cnt_d  = '0;
                    if (any_nib_bad) begin
                        req_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        req_err_d = 1'b0;
                        state_d   = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                // {bcd, bin} >> 1: the BCD LSB drops into the binary MSB
                bin_d       = {bcd_q[0], bin_q[WIDTH-1:1]};
                bcd_d       = {1'b0, bcd_q[BCD_W-1:1]};
                digit_idx_d = '0;
                if (loop_cnt_q == LCNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    loop_cnt_d = loop_cnt_q + LCNT_W'(1);
                    state_d    = ST_CHECK;
                end
            end

            ST_CHECK: begin
                // Adjust only the selected digit; >= 8 minus 3 always fits 4 bits
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if ((digit_idx_q == DIDX_W'(d)) && (bcd_q[d*4 +: 4] >= 4'd8)) begin
                        bcd_d[d*4 +: 4] = bcd_q[d*4 +: 4] - 4'd3;
                    end
                end
                if (digit_idx_q == DIDX_W'(DIGITS - 1)) begin
                    state_d = ST_SHIFT;
                end else begin
                    digit_idx_d = digit_idx_q + DIDX_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (req_err_q) begin
                    binary_d = '0;
                    err_d    = 1'b1;
                    ovf_d    = 1'b0;
                end else if (bcd_q != '0) begin
                    // Quotient left over: value exceeds the binary range
                    binary_d = '1;
                    err_d    = 1'b0;
                    ovf_d    = 1'b1;
                end else begin
                    binary_d = bin_q;
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign ready_o  = ready_q;
    assign done_o   = done_q;
    assign binary_o = binary_q;
    assign err_o    = err_q;
    assign ovf_o    = ovf_q;

endmodule : bcd_to_bin

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin (14-bit and 10-bit instances).
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;

    logic        start14, rdy14, done14, err14, ovf14;
    logic [15:0] bcd14;
    logic [13:0] bin14;

    logic        start10, rdy10, done10, err10, ovf10;
    logic [15:0] bcd10;
    logic [9:0]  bin10;

    int total;
    int bad;

    bcd_to_bin #(.WIDTH(14), .DIGITS(4)) u_dut14 (
        .clk      (clk),
        .rst      (rst),
        .bcd_i    (bcd14),
        .start_i  (start14),
        .ready_o  (rdy14),
        .done_o   (done14),
        .binary_o (bin14),
        .err_o    (err14),
        .ovf_o    (ovf14)
    );

    bcd_to_bin #(.WIDTH(10), .DIGITS(4)) u_dut10 (
        .clk      (clk),
        .rst      (rst),
        .bcd_i    (bcd10),
        .start_i  (start10),
        .ready_o  (rdy10),
        .done_o   (done10),
        .binary_o (bin10),
        .err_o    (err10),
        .ovf_o    (ovf10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] bcd);
        if (sel == 0) begin
            start14 = st;
            bcd14   = bcd;
        end else begin
            start10 = st;
            bcd10   = bcd;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic dn,
                          output logic [31:0] bin, output logic er, output logic ov);
        if (sel == 0) begin
            rdy = rdy14; dn = done14; bin = 32'(bin14); er = err14; ov = ovf14;
        end else begin
            rdy = rdy10; dn = done10; bin = 32'(bin10); er = err10; ov = ovf10;
        end
    endtask

    // Reference: decimal value from nibbles, then range/validity rules
    task automatic model(input int w, input logic [15:0] bcd,
                         output logic [31:0] exp_bin, output logic exp_err,
                         output logic exp_ovf, output int exp_busy);
        int val;
        int nib;
        exp_err = 1'b0;
        val     = 0;
        for (int i = 3; i >= 0; i--) begin
            nib = int'((bcd >> (4 * i)) & 16'hF);
            if (nib > 9) exp_err = 1'b1;
            val = val * 10 + nib;
        end
        exp_ovf = 1'b0;
        if (exp_err) begin
            exp_bin  = 32'd0;
            exp_busy = 1;
        end else begin
            if (val > (1 << w) - 1) begin
                exp_bin = 32'((1 << w) - 1);
                exp_ovf = 1'b1;
            end else begin
                exp_bin = 32'(val);
            end
            exp_busy = w + (w - 1) * 4 + 1;
        end
    endtask

    task automatic run_conv(input int sel, input logic [15:0] bcd, input bit disturb);
        int          w;
        int          cnt;
        int          exp_busy;
        logic [31:0] exp_bin;
        logic        exp_err, exp_ovf;
        logic        rdy, dn, er, ov;
        logic [31:0] bin;
        w = (sel == 0) ? 14 : 10;
        model(w, bcd, exp_bin, exp_err, exp_ovf, exp_busy);
        @(negedge clk);
        drive(sel, 1'b1, bcd);
        @(negedge clk);
        sample(sel, rdy, dn, bin, er, ov);
        cnt = 0;
        while (!rdy && cnt < 300) begin
            cnt++;
            if (disturb) drive(sel, 1'($urandom_range(0, 1)), 16'($urandom));
            else         drive(sel, 1'b0, bcd);
            @(negedge clk);
            sample(sel, rdy, dn, bin, er, ov);
        end
        drive(sel, 1'b0, bcd);
        chk($sformatf("busy[%0d:%04h]", w, bcd), 32'(cnt), 32'(exp_busy));
        chk($sformatf("done[%0d:%04h]", w, bcd), 32'(dn), 32'(1));
        chk($sformatf("bin[%0d:%04h]", w, bcd), bin, exp_bin);
        chk($sformatf("err[%0d:%04h]", w, bcd), 32'(er), 32'(exp_err));
        chk($sformatf("ovf[%0d:%04h]", w, bcd), 32'(ov), 32'(exp_ovf));
        @(negedge clk);
        sample(sel, rdy, dn, bin, er, ov);
        chk($sformatf("pulse[%0d:%04h]", w, bcd), 32'(dn), 32'(0));
        chk($sformatf("hold[%0d:%04h]", w, bcd), bin, exp_bin);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) begin
            int p;
            p = int'($urandom_range(0, 3));
            v[p*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        logic        rdy, dn, er, ov;
        logic [31:0] bin;
        int          cnt;
        int          done_seen;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);
        repeat (3) @(negedge clk);

        // Reset values on both instances
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, dn, bin, er, ov);
            chk($sformatf("rst_ready%0d", s), 32'(rdy), 32'(1));
            chk($sformatf("rst_done%0d", s), 32'(dn), 32'(0));
            chk($sformatf("rst_bin%0d", s), bin, 32'(0));
            chk($sformatf("rst_err%0d", s), 32'(er), 32'(0));
            chk($sformatf("rst_ovf%0d", s), 32'(ov), 32'(0));
        end
        rst = 1'b1;

        // Directed cases
        run_conv(0, 16'h1234, 1'b0);
        run_conv(0, 16'h0000, 1'b0);
        run_conv(0, 16'h9999, 1'b0);
        run_conv(1, 16'h1024, 1'b0);
        run_conv(1, 16'h1023, 1'b0);
        run_conv(1, 16'h9999, 1'b0);
        run_conv(0, 16'h12A4, 1'b0);
        run_conv(0, 16'h0042, 1'b0);
        run_conv(0, 16'h5678, 1'b1);

        // Start held high: back-to-back conversions
        @(negedge clk);
        drive(0, 1'b1, 16'h4321);
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            @(negedge clk);
            sample(0, rdy, dn, bin, er, ov);
            while (!rdy && cnt < 300) begin
                cnt++;
                @(negedge clk);
                sample(0, rdy, dn, bin, er, ov);
            end
            if (k == 2) drive(0, 1'b0, 16'h4321);
            chk($sformatf("b2b_busy%0d", k), 32'(cnt), 32'(67));
            chk($sformatf("b2b_done%0d", k), 32'(dn), 32'(1));
            chk($sformatf("b2b_bin%0d", k), bin, 32'd4321);
        end
        @(negedge clk);

        // Reset in the middle of a conversion
        drive(0, 1'b1, 16'h5678);
        @(negedge clk);
        drive(0, 1'b0, 16'h5678);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sample(0, rdy, dn, bin, er, ov);
        chk("midrst_ready", 32'(rdy), 32'(1));
        chk("midrst_bin", bin, 32'(0));
        chk("midrst_done", 32'(dn), 32'(0));
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done14) done_seen++;
        end
        chk("midrst_nodone", 32'(done_seen), 32'(0));

        // Randomized requests against the reference model
        for (int i = 0; i < 25; i++) begin
            run_conv(0, rand_bcd(), 1'($urandom_range(0, 1)));
            run_conv(1, rand_bcd(), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bcd_to_bin

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter, the inverse of the DTH binary-to-BCD path. It takes a packed decimal value (for example a setpoint or threshold entered on the keypad/display side) and produces an unsigned binary value of the measurement resolution. It uses reverse double-dabble: shift right, then subtract 3 from each BCD digit that is ≥ 8. One digit is processed per cycle, which keeps area small. It sits between the user-interface/config registers and the comparison logic.

## Interface
- `WIDTH`, default `` `RES_WIDTH ``: width of the binary result.
- `DIGITS`, default `` `DECIMAL_DIGITS ``: number of BCD digits on the input.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-low.
- `bcd_i`, in, DIGITS*4: packed BCD input; digit 0 is in bits [3:0].
- `start_i`, in, 1: conversion request; sampled only in IDLE.
- `ready_o`, out, 1: high exactly when FSM is IDLE. Reset value 1.
- `done_o`, out, 1: one-cycle pulse when `binary_o`/flags update. Reset value 0.
- `binary_o`, out, WIDTH: registered result; holds until the next `done_o`. Reset value 0.
- `err_o`, out, 1: last request contained a nibble > 9. Reset value 0.
- `ovf_o`, out, 1: last request's value > 2^WIDTH−1. Reset value 0.

## Operation
- One-hot FSM, 4 states: IDLE, SHIFT, DIGIT_CHECK, DONE. An illegal encoding goes to IDLE on the next edge.
- Internal registers: `bcd_r` (DIGITS*4), `bin_r` (WIDTH), `digit_idx` (clog2(DIGITS)), `loop_cnt` (clog2(WIDTH+1)), `err_r`.
- **IDLE:** if `start_i`:
  - latch `bcd_i` into `bcd_r`; clear `bin_r`, `digit_idx` and `loop_cnt`.
  - if any nibble of `bcd_i` > 9: set `err_r`=1 and go to DONE (no conversion).
  - otherwise set `err_r`=0 and go to SHIFT.
  - Without `start_i`, stay in IDLE.
- **SHIFT:** shift the concatenation {bcd_r, bin_r} right by 1. `bin_r[WIDTH−1]` takes `bcd_r[0]`; `bcd_r` MSB is filled with 0. Clear `digit_idx`.
  - if `loop_cnt` == WIDTH−1: go to DONE.
  - otherwise increment `loop_cnt` and go to DIGIT_CHECK.
- **DIGIT_CHECK:** if digit[`digit_idx`] ≥ 8, replace it with digit − 3 (4-bit, no borrow out). Only one digit is touched per cycle.
  - if `digit_idx` == DIGITS−1: go to SHIFT.
  - otherwise increment `digit_idx` and stay.
- **DONE:** go to IDLE and pulse `done_o`=1.
  - `err_r`=1: `binary_o`=0, `err_o`=1, `ovf_o`=0.
  - else if `bcd_r` ≠ 0 (quotient left over): `binary_o`={WIDTH{1}} (saturate), `ovf_o`=1, `err_o`=0.
  - else: `binary_o`=`bin_r`, both flags 0.
- `start_i` outside IDLE is ignored. There is no queueing, and `bcd_i` may change freely after the accepting edge.

## Timing
- Accepting edge = the IDLE edge with `start_i`=1.
- Valid input: busy (ready_o=0) for WIDTH + (WIDTH−1)·DIGITS + 1 cycles. That is 67 cycles for WIDTH=14, DIGITS=4.
- Invalid input: busy for 1 cycle (DONE only).
- `done_o` is high in the first IDLE cycle after DONE, together with the new `binary_o`. `ready_o` is also high in that cycle, so a new `start_i` may be accepted on that same edge (back-to-back).
- `rst`=0 at any edge, including mid-conversion: FSM → IDLE, all outputs and internal registers reset on that edge. A conversion in progress is discarded with no `done_o`.
- Arithmetic is unsigned. Digit adjust is applied only to digits ≥ 8, which always yields a 5..12 result fitting 4 bits.

## Structure
- Shared package/header (`DTH_params.v`) holds `` `RES_WIDTH ``, `` `DECIMAL_DIGITS `` and the one-hot state encoding constants. Those encodings are shared with the forward converter, so both FSMs decode identically.
- Single flat module; no sub-module needed. The digit > 9 check is a generate loop over nibbles ORed into one signal.

## Test plan
- WIDTH=14, DIGITS=4, `bcd_i`=16'h1234, pulse `start_i` → after 67 cycles `done_o`=1, `binary_o`=1234, err_o=0, ovf_o=0.
- `bcd_i`=16'h0000 and 16'h9999 → `binary_o`=0 and 9999 respectively, no flags.
- WIDTH=10, DIGITS=4, `bcd_i`=16'h1024 → `binary_o`=10'h3FF, ovf_o=1. Then `bcd_i`=16'h1023 → `binary_o`=1023, ovf_o=0.
- `bcd_i`=16'h12A4 → busy 1 cycle, `done_o`=1, `binary_o`=0, err_o=1. A following valid request clears err_o.
- `start_i` toggled and `bcd_i` changed mid-conversion → ignored, result matches the originally latched value. `start_i` held high → back-to-back conversions, `done_o` every 67 cycles.
- `rst`=0 at cycle 20 of a conversion → next cycle ready_o=1, binary_o=0, no `done_o` pulse.
